// File: rtl/rob_retire.sv
// rob_retire: 16-entry reorder buffer with dual allocate and dual in-order retire.
// Optional ROB_CMP_BYPASS_EN lets same-edge completions retire immediately.
module rob_retire #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_valid,
    input  logic [5:0]       alloc_pd_1,
    input  logic [5:0]       alloc_pd_2,
    input  logic [6:0]       alloc_op_1,
    input  logic [6:0]       alloc_op_2,
    input  logic [5:0]       alloc_opd_1,
    input  logic [5:0]       alloc_opd_2,
    output logic             alloc_ready,
    output logic [IDX_W-1:0] alloc_idx_1,
    output logic [IDX_W-1:0] alloc_idx_2,
    input  logic             cmp_valid_1,
    input  logic [IDX_W-1:0] cmp_rob_1,
    input  logic [31:0]      cmp_data_1,
    input  logic             cmp_valid_2,
    input  logic [IDX_W-1:0] cmp_rob_2,
    input  logic [31:0]      cmp_data_2,
    input  logic             cmp_valid_3,
    input  logic [IDX_W-1:0] cmp_rob_3,
    input  logic [31:0]      cmp_data_3,
    output logic             ret_valid_1,
    output logic             ret_valid_2,
    output logic [5:0]       ret_pd_1,
    output logic [5:0]       ret_pd_2,
    output logic [5:0]       ret_opd_1,
    output logic [5:0]       ret_opd_2,
    output logic             ret_wr_1,
    output logic             ret_wr_2,
    output logic [31:0]      ret_data_1,
    output logic [31:0]      ret_data_2,
    output logic [IDX_W:0]   count,
    output logic             overflow
);

    localparam logic [IDX_W:0] READY_MAX = (IDX_W+1)'(DEPTH - 2);

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [IDX_W-1:0] h1;
    logic [IDX_W-1:0] t1;
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] done_q;
    logic [5:0]       pd_q   [DEPTH];
    logic [6:0]       op_q   [DEPTH];
    logic [5:0]       opd_q  [DEPTH];
    logic [31:0]      data_q [DEPTH];

    logic             cv [3];
    logic [IDX_W-1:0] cr [3];
    logic [31:0]      cd [3];

    logic             alloc_fire;
    logic             ok0;
    logic             ok1;
    logic [31:0]      rdata0;
    logic [31:0]      rdata1;
    logic             r1;
    logic             r2;
    logic [1:0]       nret;
    logic [IDX_W:0]   cnt_add;

    assign cv[0] = cmp_valid_1;
    assign cv[1] = cmp_valid_2;
    assign cv[2] = cmp_valid_3;
    assign cr[0] = cmp_rob_1;
    assign cr[1] = cmp_rob_2;
    assign cr[2] = cmp_rob_3;
    assign cd[0] = cmp_data_1;
    assign cd[1] = cmp_data_2;
    assign cd[2] = cmp_data_3;

    assign alloc_ready = (count <= READY_MAX);
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign t1          = tail + IDX_W'(1);
    assign h1          = head + IDX_W'(1);
    assign alloc_idx_1 = tail;
    assign alloc_idx_2 = t1;
    assign cnt_add     = alloc_fire ? (IDX_W+1)'(2) : '0;

    function automatic logic writes_reg(input logic [6:0] op);
        return !(op == 7'b0100011 || op == 7'b1100011);
    endfunction

    always_comb begin
        ok0    = done_q[head];
        ok1    = done_q[h1];
        rdata0 = data_q[head];
        rdata1 = data_q[h1];
`ifdef ROB_CMP_BYPASS_EN
        // Later ports override earlier ones, matching the stored-data priority.
        for (int k = 0; k < 3; k++) begin
            if (cv[k] && cr[k] == head) begin
                ok0    = 1'b1;
                rdata0 = cd[k];
            end
            if (cv[k] && cr[k] == h1) begin
                ok1    = 1'b1;
                rdata1 = cd[k];
            end
        end
`endif
        r1   = valid_q[head] & ok0;
        r2   = r1 & valid_q[h1] & ok1;
        nret = {1'b0, r1} + {1'b0, r2};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            valid_q     <= '0;
            done_q      <= '0;
            ret_valid_1 <= 1'b0;
            ret_valid_2 <= 1'b0;
            ret_pd_1    <= '0;
            ret_pd_2    <= '0;
            ret_opd_1   <= '0;
            ret_opd_2   <= '0;
            ret_wr_1    <= 1'b0;
            ret_wr_2    <= 1'b0;
            ret_data_1  <= '0;
            ret_data_2  <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (cv[k] && valid_q[cr[k]]) begin
                    done_q[cr[k]] <= 1'b1;
                end
            end
            if (r1) begin
                valid_q[head] <= 1'b0;
                done_q[head]  <= 1'b0;
            end
            if (r2) begin
                valid_q[h1] <= 1'b0;
                done_q[h1]  <= 1'b0;
            end
            if (alloc_fire) begin
                valid_q[tail] <= 1'b1;
                valid_q[t1]   <= 1'b1;
                done_q[tail]  <= 1'b0;
                done_q[t1]    <= 1'b0;
                tail          <= tail + IDX_W'(2);
            end else if (alloc_valid) begin
                overflow <= 1'b1;
            end
            head  <= head + IDX_W'(nret);
            count <= count + cnt_add - (IDX_W+1)'(nret);

            ret_valid_1 <= r1;
            ret_pd_1    <= r1 ? pd_q[head] : '0;
            ret_opd_1   <= r1 ? opd_q[head] : '0;
            ret_wr_1    <= r1 ? writes_reg(op_q[head]) : 1'b0;
            ret_data_1  <= r1 ? rdata0 : '0;
            ret_valid_2 <= r2;
            ret_pd_2    <= r2 ? pd_q[h1] : '0;
            ret_opd_2   <= r2 ? opd_q[h1] : '0;
            ret_wr_2    <= r2 ? writes_reg(op_q[h1]) : 1'b0;
            ret_data_2  <= r2 ? rdata1 : '0;
        end
    end

    // Payload storage is qualified by valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (cv[k] && valid_q[cr[k]]) begin
                    data_q[cr[k]] <= cd[k];
                end
            end
            if (alloc_fire) begin
                pd_q[tail]  <= alloc_pd_1;
                op_q[tail]  <= alloc_op_1;
                opd_q[tail] <= alloc_opd_1;
                pd_q[t1]    <= alloc_pd_2;
                op_q[t1]    <= alloc_op_2;
                opd_q[t1]   <= alloc_opd_2;
            end
        end
    end

endmodule
